// File: rtl/arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state codes,
// the CPU owner code and width helpers for owner / pointer fields.
package arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int OWNER_CPU = 0;

   // Owner code: 0 = CPU, i+1 = DMA requester i.
   function automatic int owner_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Round-robin pointer width, never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Ports: req (request vector), ptr (scan start) -> valid, idx (winner).
module rr_picker
   import arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]          req,
   input  logic [ptr_w(N)-1:0]   ptr,
   output logic                  valid,
   output logic [ptr_w(N)-1:0]   idx
);

   localparam int PW = ptr_w(N);

   logic          hi_v;
   logic [PW-1:0] hi_idx;
   logic [PW-1:0] lo_idx;

   // hi_* is the first request at or above ptr; lo_* is the first
   // request overall, used when the scan has to wrap around.
   always_comb begin
      hi_v   = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_idx = PW'(j);
            if (j >= int'(ptr)) begin
               hi_v   = 1'b1;
               hi_idx = PW'(j);
            end
         end
      end
      valid = |req;
      idx   = hi_v ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter: CPU operand fetch vs N_DMA requesters.
// Ports: clk, reset (sync, active-low), cpu_req/ack, dma_req/dma_gnt/
// dma_done, mem_start/mem_sel/mem_done, busy, timeout_err (sticky).
module mem_bus_arbiter
   import arb_pkg::*;
#(
   parameter int N_DMA     = 2,
   parameter int CPU_BURST = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cpu_req,
   output logic                      ack,
   input  logic [N_DMA-1:0]          dma_req,
   output logic [N_DMA-1:0]          dma_gnt,
   output logic [N_DMA-1:0]          dma_done,
   output logic                      mem_start,
   output logic [owner_w(N_DMA)-1:0] mem_sel,
   input  logic                      mem_done,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int SW = owner_w(N_DMA);
   localparam int PW = ptr_w(N_DMA);
   localparam int KW = $clog2(CPU_BURST + 1);
   localparam int WW = $clog2(TIMEOUT);

   logic [1:0]       state;
   logic [KW-1:0]    cpu_streak;
   logic [PW-1:0]    rr_ptr;
   logic [WW-1:0]    wdog;

   logic             pick_v;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    ptr_nxt;
   logic [SW-1:0]    dma_own;
   logic [N_DMA-1:0] gnt_oh;
   logic [N_DMA-1:0] done_oh;
   logic             dma_any;
   logic             cpu_wins;
   logic             wd_exp;

   rr_picker #(
      .N     (N_DMA)
   ) u_pick (
      .req   (dma_req),
      .ptr   (rr_ptr),
      .valid (pick_v),
      .idx   (pick_idx)
   );

   always_comb begin
      dma_any  = |dma_req;
      // Starvation guard: a full CPU streak yields to pending DMA.
      cpu_wins = cpu_req &&
                 !(cpu_streak == KW'(CPU_BURST) && dma_any);
      ptr_nxt  = (int'(pick_idx) == N_DMA - 1) ?
                 '0 : pick_idx + PW'(1);
      dma_own  = SW'(pick_idx) + SW'(1);
      gnt_oh   = N_DMA'(1) << pick_idx;
      done_oh  = N_DMA'(1) << (mem_sel - SW'(1));
      wd_exp   = (wdog == WW'(TIMEOUT - 1));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cpu_streak  <= '0;
         rr_ptr      <= '0;
         wdog        <= '0;
         ack         <= 1'b0;
         dma_gnt     <= '0;
         dma_done    <= '0;
         mem_start   <= 1'b0;
         mem_sel     <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cpu_wins) begin
                  mem_sel   <= SW'(OWNER_CPU);
                  mem_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_START;
                  if (!dma_any)
                     cpu_streak <= '0;
                  else if (cpu_streak != KW'(CPU_BURST))
                     cpu_streak <= cpu_streak + KW'(1);
               end else if (pick_v) begin
                  mem_sel    <= dma_own;
                  dma_gnt    <= gnt_oh;
                  rr_ptr     <= ptr_nxt;
                  cpu_streak <= '0;
                  mem_start  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_START;
               end
            end
            ST_START: begin
               mem_start <= 1'b0;
               wdog      <= '0;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               // A timeout still completes so the requester never hangs.
               if (mem_done || wd_exp) begin
                  if (!mem_done)
                     timeout_err <= 1'b1;
                  if (mem_sel == SW'(OWNER_CPU))
                     ack <= 1'b1;
                  else
                     dma_done <= done_oh;
                  state <= ST_RESP;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            ST_RESP: begin
               ack      <= 1'b0;
               dma_done <= '0;
               dma_gnt  <= '0;
               mem_sel  <= '0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: grant scoreboard,
// latency / completion monitor and a simple memory responder.
module tb_mem_bus_arbiter;

   localparam int N_DMA   = 2;
   localparam int TIMEOUT = 16;

   logic             clk;
   logic             reset;
   logic             cpu_req;
   logic             ack;
   logic [N_DMA-1:0] dma_req;
   logic [N_DMA-1:0] dma_gnt;
   logic [N_DMA-1:0] dma_done;
   logic             mem_start;
   logic [1:0]       mem_sel;
   logic             mem_done;
   logic             busy;
   logic             timeout_err;

   int total = 0;
   int bad   = 0;

   int exp_q[$];
   int cur_own  = 0;
   int cyc_n    = 0;
   int st_cyc   = 0;
   int lat_obs  = 0;
   int done_cnt = 0;
   int mem_lat  = 1;
   int rcnt     = 0;

   mem_bus_arbiter #(
      .N_DMA       (N_DMA),
      .CPU_BURST   (4),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .ack         (ack),
      .dma_req     (dma_req),
      .dma_gnt     (dma_gnt),
      .dma_done    (dma_done),
      .mem_start   (mem_start),
      .mem_sel     (mem_sel),
      .mem_done    (mem_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Memory model: mem_done goes high mem_lat cycles after mem_start
   // (mem_lat == 0 means it never answers).
   always @(negedge clk) begin
      if (mem_start) begin
         rcnt     <= mem_lat;
         mem_done <= 1'b0;
      end else begin
         if (rcnt > 0)
            rcnt <= rcnt - 1;
         mem_done <= (rcnt == 1);
      end
   end

   // Grant scoreboard and completion monitor.
   always @(negedge clk) begin
      int e;
      cyc_n <= cyc_n + 1;
      if (mem_start) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_grant", int'(mem_sel), -1);
         end else begin
            e = exp_q.pop_front();
            chk("grant_sel", int'(mem_sel), e);
            chk("grant_gnt", int'(dma_gnt), (e == 0) ? 0 : (1 << (e - 1)));
            cur_own <= e;
            st_cyc  <= cyc_n;
         end
      end
      if (ack) begin
         chk("ack_owner", cur_own, 0);
         chk("ack_nodone", int'(dma_done), 0);
         lat_obs <= cyc_n - st_cyc;
      end
      if (dma_done != '0) begin
         chk("done_oh", int'(dma_done),
             (cur_own == 0) ? 0 : (1 << (cur_own - 1)));
         lat_obs  <= cyc_n - st_cyc;
         done_cnt <= done_cnt + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_starts(input int n);
      int seen = 0;
      for (int i = 0; i < 600 && seen < n; i++) begin
         @(negedge clk);
         if (mem_start) seen++;
      end
      chk("starts", seen, n);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++)
         @(negedge clk);
      chk("idle", int'(busy), 0);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      chk("rst_busy", int'(busy), 0);
      reset = 1'b1;
   endtask

   initial begin
      int d0;
      int k;
      reset    = 1'b0;
      cpu_req  = 1'b1;
      dma_req  = '0;
      mem_done = 1'b0;

      // Reset held with cpu_req high: nothing starts.
      tick();
      chk("rst0_outs", int'({ack, mem_start, busy, timeout_err,
                             dma_gnt, dma_done, mem_sel}), 0);
      tick();
      chk("rst1_outs", int'({ack, mem_start, busy, timeout_err,
                             dma_gnt, dma_done, mem_sel}), 0);
      exp_q.push_back(0);
      mem_lat = 1;
      reset   = 1'b1;

      // Minimum-latency CPU transaction.
      tick();
      chk("c1_start", int'(mem_start), 1);
      chk("c1_busy", int'(busy), 1);
      chk("c1_sel", int'(mem_sel), 0);
      chk("c1_gnt", int'(dma_gnt), 0);
      tick();
      chk("c2_start", int'(mem_start), 0);
      chk("c2_busy", int'(busy), 1);
      chk("c2_ack", int'(ack), 0);
      tick();
      chk("c3_ack", int'(ack), 1);
      chk("c3_busy", int'(busy), 1);
      chk("c3_gnt", int'(dma_gnt), 0);
      cpu_req = 1'b0;
      tick();
      chk("c4_ack", int'(ack), 0);
      chk("c4_busy", int'(busy), 0);
      chk("min_lat", lat_obs, 2);
      tick();

      // CPU streak vs. held DMA0 request.
      k = 0;
      foreach (exp_q[i]) k++;
      chk("q_before_burst", k, 0);
      exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(1);
      cpu_req = 1'b1;
      dma_req = 2'b01;
      wait_starts(10);
      cpu_req = 1'b0;
      dma_req = '0;
      wait_idle();

      // Round robin between two DMA requesters from a fresh pointer.
      do_reset();
      exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(1); exp_q.push_back(2);
      dma_req = 2'b11;
      wait_starts(4);
      dma_req = '0;
      wait_idle();
      chk("rr_lat", lat_obs, 2);

      // Watchdog: no mem_done, then a good transaction.
      do_reset();
      chk("to_clear0", int'(timeout_err), 0);
      exp_q.push_back(0);
      mem_lat = 0;
      cpu_req = 1'b1;
      wait_starts(1);
      cpu_req = 1'b0;
      wait_idle();
      chk("to_lat", lat_obs, TIMEOUT + 1);
      chk("to_err", int'(timeout_err), 1);
      exp_q.push_back(0);
      mem_lat = 2;
      cpu_req = 1'b1;
      wait_starts(1);
      cpu_req = 1'b0;
      wait_idle();
      chk("good_lat", lat_obs, 3);
      chk("to_sticky", int'(timeout_err), 1);
      do_reset();
      chk("to_clear1", int'(timeout_err), 0);

      // Reset during WAIT abandons the DMA transaction.
      tick();
      exp_q.push_back(1);
      mem_lat = 0;
      dma_req = 2'b01;
      wait_starts(1);
      tick();
      tick();
      tick();
      d0    = done_cnt;
      reset = 1'b0;
      tick();
      chk("ab_busy", int'(busy), 0);
      chk("ab_gnt", int'(dma_gnt), 0);
      chk("ab_sel", int'(mem_sel), 0);
      tick();
      chk("ab_nodone", done_cnt, d0);
      exp_q.push_back(1);
      mem_lat = 1;
      reset   = 1'b1;
      wait_starts(1);
      k = 0;
      for (int i = 0; i < 50 && !dma_done[0]; i++) begin
         tick();
         k++;
      end
      chk("re_done", int'(dma_done[0]), 1);
      dma_req = '0;
      wait_idle();
      chk("re_cnt", done_cnt, d0 + 1);
      chk("q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
